// File: rtl/mod2011_pkg.sv
// -----------------------------------------------------------------------------
// mod2011_pkg
// Shared constants, state encoding and fold helper for the mod-2011 stream
// sequencer and its x_100 mod-2011 reducer.
// -----------------------------------------------------------------------------
package mod2011_pkg;

    localparam int unsigned MOD    = 2011;
    localparam int unsigned W_IN   = 100;
    localparam int unsigned W_R    = 11;
    localparam int unsigned W_FOLD = 22;
    localparam int unsigned W_ACC  = W_R + 1;
    localparam int unsigned W_WCNT = 16;

    // 2^100 mod 2011
    localparam logic [W_R-1:0] POW100 = 11'd1450;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CHUNK = 2'd1,
        FOLD  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Horner fold term r*2^100 + c, pre-reduction; worst case 2,916,510 fits 22 bits
    function automatic logic [W_FOLD-1:0] fold_sum(input logic [W_R-1:0] r,
                                                   input logic [W_R-1:0] c);
        return (W_FOLD'(r) * W_FOLD'(POW100)) + W_FOLD'(c);
    endfunction

endpackage

// File: rtl/x_100_mod_2011.sv
// -----------------------------------------------------------------------------
// x_100_mod_2011
// Combinational reducer: r = x mod 2011 for a 100-bit x. Result is always
// in 0..2010.
// Ports:
//   x  in  100  value to reduce
//   r  out 11   residue
// -----------------------------------------------------------------------------
module x_100_mod_2011
    import mod2011_pkg::*;
(
    input  logic [W_IN-1:0] x,
    output logic [W_R-1:0]  r
);

    logic [W_ACC-1:0] acc;

    // MSB-first binary long division: acc stays < 2011, so 2*acc+bit < 4022
    // and a single conditional subtract restores the invariant each step.
    always_comb begin
        acc = '0;
        for (int i = int'(W_IN) - 1; i >= 0; i--) begin
            acc = {acc[W_ACC-2:0], x[i]};
            if (acc >= W_ACC'(MOD)) begin
                acc = acc - W_ACC'(MOD);
            end
        end
        r = acc[W_R-1:0];
    end

endmodule

// File: rtl/mod2011_stream_seq.sv
// -----------------------------------------------------------------------------
// mod2011_stream_seq
// Streams an arbitrarily long operand (most-significant 100-bit word first)
// and returns its residue mod 2011. One shared x_100 mod-2011 reducer is
// time-multiplexed per word: CHUNK reduces the word, FOLD applies the Horner
// step r <- (r*2^100 + w) mod 2011.
//
// Ports:
//   clk      in   1    clock, rising edge
//   rst      in   1    synchronous active-high reset
//   s_valid  in   1    input word valid
//   s_ready  out  1    word accepted this cycle (WAIT only)
//   s_data   in   100  operand word, MS word first
//   s_last   in   1    final (least-significant) word
//   m_valid  out  1    residue valid (DONE only)
//   m_ready  in   1    consumer accepts residue
//   m_rem    out  11   residue, 0..2010
//   m_wcnt   out  16   operand word count (only with MOD2011_SEQ_WCNT_EN)
//
// Build option: define MOD2011_SEQ_WCNT_EN to add the saturating word counter
// and the m_wcnt port.
// -----------------------------------------------------------------------------
module mod2011_stream_seq
    import mod2011_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W_IN-1:0]   s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [W_R-1:0]    m_rem
`ifdef MOD2011_SEQ_WCNT_EN
    ,
    output logic [W_WCNT-1:0] m_wcnt
`endif
);

    seq_state_t       state_q, state_d;
    logic [W_IN-1:0]  data_q,  data_d;
    logic             last_q,  last_d;
    logic [W_R-1:0]   c_q,     c_d;
    logic [W_R-1:0]   r_q,     r_d;
    logic [W_R-1:0]   m_rem_d;
    logic             s_ready_d;
    logic             m_valid_d;

    logic [W_IN-1:0]  red_in;
    logic [W_R-1:0]   red_out;
    logic [W_FOLD-1:0] fold_c;

    logic             in_hs_c;
    logic             out_hs_c;

    assign in_hs_c  = s_valid & s_ready;
    assign out_hs_c = m_valid & m_ready;

    // Fold operand from registered values only
    assign fold_c = fold_sum(r_q, c_q);

    x_100_mod_2011 u_reducer (
        .x (red_in),
        .r (red_out)
    );

    // Next-state, reducer mux and next-output logic
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        c_d     = c_q;
        r_d     = r_q;
        m_rem_d = m_rem;
        red_in  = data_q;

        case (state_q)
            WAIT: begin
                if (in_hs_c) begin
                    data_d  = s_data;
                    last_d  = s_last;
                    state_d = CHUNK;
                end
            end
            CHUNK: begin
                red_in  = data_q;
                c_d     = red_out;
                state_d = FOLD;
            end
            FOLD: begin
                red_in = W_IN'(fold_c);
                r_d    = red_out;
                if (last_q) begin
                    m_rem_d = red_out;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (out_hs_c) begin
                    r_d     = '0;
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = WAIT;
            end
        endcase

        // Handshake flags registered from the next state so they track it exactly
        s_ready_d = (state_d == WAIT);
        m_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            data_q  <= '0;
            last_q  <= 1'b0;
            c_q     <= '0;
            r_q     <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_rem   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            c_q     <= c_d;
            r_q     <= r_d;
            s_ready <= s_ready_d;
            m_valid <= m_valid_d;
            m_rem   <= m_rem_d;
        end
    end

`ifdef MOD2011_SEQ_WCNT_EN
    logic [W_WCNT-1:0] wcnt_d;

    // Word counter: saturating on input handshakes, cleared on residue handshake
    always_comb begin
        wcnt_d = m_wcnt;
        if (out_hs_c) begin
            wcnt_d = '0;
        end else if (in_hs_c && (m_wcnt != {W_WCNT{1'b1}})) begin
            wcnt_d = m_wcnt + W_WCNT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_wcnt <= '0;
        end else begin
            m_wcnt <= wcnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mod2011_stream_seq.sv
// -----------------------------------------------------------------------------
// tb_mod2011_stream_seq
// Self-checking bench for mod2011_stream_seq. Expected residues come from a
// big-integer model: the whole operand is concatenated and reduced with %.
// -----------------------------------------------------------------------------
module tb_mod2011_stream_seq;
    import mod2011_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [W_IN-1:0] s_data;
    logic            s_last;
    logic            m_valid;
    logic            m_ready;
    logic [W_R-1:0]  m_rem;
`ifdef MOD2011_SEQ_WCNT_EN
    logic [15:0]     m_wcnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cyc = 0;

    typedef logic [W_IN-1:0] word_arr_t [5];

    mod2011_stream_seq dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_rem   (m_rem)
`ifdef MOD2011_SEQ_WCNT_EN
        ,
        .m_wcnt  (m_wcnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: residue of the whole multi-word integer
    function automatic logic [W_R-1:0] ref_mod(input word_arr_t w, input int n);
        logic [511:0] big;
        big = '0;
        for (int i = 0; i < n; i++) big = (big << W_IN) | 512'(w[i]);
        return W_R'(big % 512'd2011);
    endfunction

    function automatic logic [W_IN-1:0] rand_word();
        logic [127:0] t;
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return W_IN'($urandom_range(0, 4100));
            default: begin
                t = {$urandom, $urandom, $urandom, $urandom};
                return W_IN'(t);
            end
        endcase
    endfunction

    // Offer one word after 'gap' idle WAIT cycles; acc = accept cycle or -1
    task automatic send_word(input logic [W_IN-1:0] w, input logic last,
                             input int gap, output int acc);
        int idle;
        idle = 0;
        acc  = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_ready && idle >= gap) begin
                s_valid = 1'b1;
                s_data  = w;
                s_last  = last;
                acc     = cyc;
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            s_valid = 1'b0;
            if (s_ready) idle++;
        end
    endtask

    // Wait for m_valid; mcyc = first valid cycle or -1
    task automatic wait_result(output logic [W_R-1:0] rem, output logic [15:0] wc,
                               output int mcyc);
        rem  = '0;
        wc   = '0;
        mcyc = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (m_valid) begin
                rem  = m_rem;
`ifdef MOD2011_SEQ_WCNT_EN
                wc   = m_wcnt;
`endif
                mcyc = cyc;
                return;
            end
        end
    endtask

    // Residue handshake after 'hold' cycles of m_ready low
    task automatic ack(input int hold);
        for (int i = 0; i < hold; i++) @(negedge clk);
        @(negedge clk);
        m_ready = 1'b1;
        hs_cyc  = cyc;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic run_operand(input word_arr_t w, input int n, input int gap,
                               output logic [W_R-1:0] rem, output logic [15:0] wc,
                               output int lat);
        int acc, first, mcyc;
        first = -1;
        lat   = -1;
        rem   = '0;
        wc    = '0;
        for (int i = 0; i < n; i++) begin
            send_word(w[i], (i == n - 1), (i == 0) ? 0 : gap, acc);
            if (acc < 0) return;
            if (i == 0) first = acc;
        end
        wait_result(rem, wc, mcyc);
        if (mcyc >= 0) lat = mcyc - first;
    endtask

    task automatic test_reset();
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        checks++;
        if (m_rem !== '0) begin errors++; $display("FAIL reset_m_rem got=%0d exp=0", m_rem); end
`ifdef MOD2011_SEQ_WCNT_EN
        checks++;
        if (m_wcnt !== 16'd0) begin errors++; $display("FAIL reset_m_wcnt got=%0d exp=0", m_wcnt); end
`endif
    endtask

    task automatic test_single_word();
        word_arr_t w;
        logic [W_R-1:0] rem;
        logic [15:0] wc;
        int lat;
        w = '{default: '0};
        w[0] = W_IN'(2011);
        run_operand(w, 1, 0, rem, wc, lat);
        checks++;
        if (rem !== 11'd0) begin errors++; $display("FAIL single_2011 got=%0d exp=0", rem); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL single_latency got=%0d exp=3", lat); end
        ack(0);
        w[0] = '1;
        run_operand(w, 1, 0, rem, wc, lat);
        checks++;
        if (rem !== 11'd1449) begin errors++; $display("FAIL single_all_ones got=%0d exp=1449", rem); end
        ack(0);
    endtask

    task automatic test_two_words();
        word_arr_t w;
        logic [W_R-1:0] rem;
        logic [15:0] wc;
        int lat;
        w = '{default: '0};
        w[0] = W_IN'(1);
        w[1] = W_IN'(0);
        run_operand(w, 2, 0, rem, wc, lat);
        checks++;
        if (rem !== 11'd1450) begin errors++; $display("FAIL two_1_0 got=%0d exp=1450", rem); end
`ifdef MOD2011_SEQ_WCNT_EN
        checks++;
        if (wc !== 16'd2) begin errors++; $display("FAIL two_wcnt got=%0d exp=2", wc); end
`endif
        ack(0);
        w[1] = W_IN'(561);
        run_operand(w, 2, 0, rem, wc, lat);
        checks++;
        if (rem !== 11'd0) begin errors++; $display("FAIL two_1_561 got=%0d exp=0", rem); end
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL two_latency got=%0d exp=6", lat); end
        ack(0);
    endtask

    task automatic test_gap();
        word_arr_t w;
        logic [W_R-1:0] rem;
        logic [15:0] wc;
        int lat;
        w = '{default: '0};
        w[0] = W_IN'(1);
        w[1] = W_IN'(561);
        run_operand(w, 2, 5, rem, wc, lat);
        checks++;
        if (rem !== 11'd0) begin errors++; $display("FAIL gap_rem got=%0d exp=0", rem); end
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL gap_latency got=%0d exp=11", lat); end
        ack(0);
    endtask

    // Residue held under backpressure; queued word enters right after handshake
    task automatic test_hold_done();
        word_arr_t w;
        logic [W_R-1:0] rem, exp_rem;
        logic [15:0] wc;
        int lat, mcyc, acc;
        w = '{default: '0};
        w[0] = rand_word();
        w[1] = rand_word();
        exp_rem = ref_mod(w, 2);
        run_operand(w, 2, 0, rem, wc, lat);
        checks++;
        if (rem !== exp_rem) begin errors++; $display("FAIL hold_rem got=%0d exp=%0d", rem, exp_rem); end
        s_valid = 1'b1;
        s_data  = W_IN'(37);
        s_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_rem !== exp_rem || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc%0d got v=%0b rem=%0d rdy=%0b exp v=1 rem=%0d rdy=0",
                         i, m_valid, m_rem, s_ready, exp_rem);
            end
        end
        ack(0);
        @(negedge clk);
        acc = cyc;
        checks++;
        if (s_ready !== 1'b1 || acc !== hs_cyc + 1) begin
            errors++;
            $display("FAIL back_to_back_accept got rdy=%0b cyc=%0d exp rdy=1 cyc=%0d", s_ready, acc, hs_cyc + 1);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_result(rem, wc, mcyc);
        checks++;
        if (rem !== 11'd37) begin errors++; $display("FAIL after_hold_37 got=%0d exp=37", rem); end
        checks++;
        if (mcyc - acc !== 3) begin errors++; $display("FAIL after_hold_latency got=%0d exp=3", mcyc - acc); end
`ifdef MOD2011_SEQ_WCNT_EN
        checks++;
        if (wc !== 16'd1) begin errors++; $display("FAIL after_hold_wcnt got=%0d exp=1", wc); end
`endif
        ack(0);
    endtask

    task automatic test_reset_mid();
        word_arr_t w;
        logic [W_R-1:0] rem;
        logic [15:0] wc;
        int lat, acc;
        send_word(W_IN'(12345), 1'b0, 0, acc);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_rem !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got rdy=%0b v=%0b rem=%0d exp rdy=1 v=0 rem=0",
                     s_ready, m_valid, m_rem);
        end
`ifdef MOD2011_SEQ_WCNT_EN
        checks++;
        if (m_wcnt !== 16'd0) begin errors++; $display("FAIL reset_mid_wcnt got=%0d exp=0", m_wcnt); end
`endif
        w = '{default: '0};
        w[0] = W_IN'(4022);
        run_operand(w, 1, 0, rem, wc, lat);
        checks++;
        if (rem !== 11'd0) begin errors++; $display("FAIL reset_mid_4022 got=%0d exp=0", rem); end
        ack(0);
    endtask

    task automatic test_random();
        word_arr_t w;
        logic [W_R-1:0] rem, exp_rem;
        logic [15:0] wc;
        int n, gap, lat;
        for (int t = 0; t < 25; t++) begin
            n   = $urandom_range(1, 5);
            gap = $urandom_range(0, 2);
            for (int i = 0; i < 5; i++) w[i] = rand_word();
            exp_rem = ref_mod(w, n);
            run_operand(w, n, gap, rem, wc, lat);
            checks++;
            if (rem !== exp_rem || lat !== 3 * n + gap * (n - 1)) begin
                errors++;
                $display("FAIL random_%0d n=%0d got rem=%0d lat=%0d exp rem=%0d lat=%0d",
                         t, n, rem, lat, exp_rem, 3 * n + gap * (n - 1));
            end
`ifdef MOD2011_SEQ_WCNT_EN
            checks++;
            if (wc !== 16'(n)) begin errors++; $display("FAIL random_wcnt_%0d got=%0d exp=%0d", t, wc, n); end
`endif
            ack($urandom_range(0, 3));
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_single_word();
        test_two_words();
        test_gap();
        test_hold_done();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod2011_stream_seq.md
# mod2011_stream_seq

Sequencer that computes the residue mod 2011 of an arbitrarily long operand streamed most-significant 100-bit word first. It schedules a single shared combinational x_100 mod-2011 reducer across two phases per word: chunk reduction, then Horner fold. It sits between an operand-producing stream source and a residue consumer, with valid/ready handshakes on both sides.

## Interface
- `W_IN`, 100: stream word width; fixed by the reducer input width.
- `W_R`, 11: residue width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  sequencer accepts a word this cycle.
- `s_data`  in  100  operand word, MS word first.
- `s_last`  in  1  marks the final (least-significant) word of the operand.
- `m_valid`  out  1  residue valid.
- `m_ready`  in  1  consumer accepts residue.
- `m_rem`  out  11  residue, range 0..2010.
- `m_wcnt`  out  16  words in the operand; present only with `MOD2011_SEQ_WCNT_EN`.

## Operation
- Horner recurrence: r ← (r·2^100 + w) mod 2011, with r = 0 at operand start. 2^100 mod 2011 = 1450 (constant `POW100`).
- One reducer instance, input multiplexed by state. The reducer is combinational, 100-bit in, 11-bit out, and the result is always < 2011.
- States:
  - WAIT: `s_ready` = 1. On `s_valid & s_ready`, capture `data_q` ← `s_data` and `last_q` ← `s_last`, then go to CHUNK.
  - CHUNK: reducer input = `data_q`; `c_q` ← reducer output; go to FOLD.
  - FOLD: reducer input = zero-extended (`r_q`·1450 + `c_q`); `r_q` ← reducer output. If `last_q`, go to DONE; otherwise go to WAIT.
  - DONE: `m_valid` = 1, `m_rem` = `r_q`. On `m_ready`, clear `r_q` to 0 and go to WAIT.
- Fold width: max 2010·1450 + 2010 = 2,916,510, so a 22-bit product/sum is sufficient; zero-extend it to 100 bits. Compute the product from registered `r_q` and `c_q` only.
- `s_ready` is asserted only in WAIT; `s_ready` is 0 in CHUNK, FOLD and DONE, regardless of `s_valid`.
- `m_valid` is asserted only in DONE and holds stable with `m_rem` until `m_ready`.
- An input with `s_valid` high in DONE is not accepted until after the residue handshake completes.
- A single-word operand (`s_last` on the first word) yields w mod 2011, since r = 0 before the fold.
- Reducer inputs in WAIT and DONE are don't-care; drive `data_q` to avoid extra mux toggling.

## Timing
- Reset: state = WAIT, `r_q` = 0, `c_q` = 0, `data_q` = 0, `last_q` = 0, `s_ready` = 1, `m_valid` = 0, `m_rem` = 0, `m_wcnt` = 0.
- Per word: 3 cycles minimum (WAIT accept, CHUNK, FOLD). An N-word operand makes `m_valid` rise 3N cycles after the first accept edge, with no stalls.
- Next operand: first word accepted no earlier than 1 cycle after the `m_ready` handshake.
- Reset asserted mid-operand: abandon the operand and return to reset values next edge. No partial residue is emitted.
- Source gaps (`s_valid` low in WAIT) only stretch WAIT; accumulated `r_q` is kept.

## Configuration
- `MOD2011_SEQ_WCNT_EN` defined:
  - Add the `m_wcnt` port and a 16-bit counter, incremented on each input handshake and saturating at 65535.
  - `m_wcnt` is valid with `m_valid` and held during DONE.
  - Counter clears to 0 on the residue handshake and on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `mod2011_pkg`:
  - `MOD` = 2011, `W_IN` = 100, `W_R` = 11, `POW100` = 1450 (11 bits), `W_FOLD` = 22.
  - State enum {WAIT, CHUNK, FOLD, DONE}.
- One sub-module: the existing `x_100_mod_2011`, instantiated exactly once. No second reducer and no `%` operator in this block.

## Test plan
- Single word `s_data` = 2011, `s_last` = 1 → `m_rem` = 0; `m_valid` rises 3 cycles after accept.
- Single word `s_data` = 2^100−1, `s_last` = 1 → `m_rem` = 1449.
- Two words, hi = 1 then lo = 0 (`s_last` on lo) → `m_rem` = 1450; `m_wcnt` = 2 when enabled.
- Two words, hi = 1 then lo = 561 → `m_rem` = 0 (1450 + 561 = 2011). Same operand with `s_valid` gapped 5 cycles between words → same result, `m_valid` 5 cycles later.
- `m_ready` held low 10 cycles in DONE with `s_valid` high → `m_valid`/`m_rem` stable and `s_ready` = 0 throughout. After the handshake, a new single word 37 → `m_rem` = 37 (`r_q` was cleared).
- `rst` pulsed during FOLD of word 1 of a 3-word operand → outputs at reset values next cycle. A following single word 4022 → `m_rem` = 0.
